// File: rtl/shake256_absorb.sv
// SHAKE256 sponge absorb stage: XORs 64-bit message lanes into the rate portion
// of the Keccak state, applies SHAKE padding and hands off to the permutation.
module shake256_absorb (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      restart,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [63:0]               in_data,
    input  logic                      in_last,
    input  logic [3:0]                in_bytes,
    output logic                      perm_start,
    input  logic                      perm_done,
    input  logic [0:4][0:4][0:63]     perm_state_in,
    output logic [0:4][0:4][0:63]     state_out,
    output logic                      absorb_done
);

    typedef enum logic [2:0] {ABSORB, PERM, PAD_BLOCK, PERM_FINAL, DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [4:0]              r_cnt, w_cnt_nxt;
    logic                    r_pend, w_pend_nxt;
    logic                    r_perm_start, w_perm_start_nxt;
    logic [0:4][0:4][0:63]   r_st, w_st_nxt;
    logic [63:0]             w_xor [17];
    logic [63:0]             w_mask;
    logic [3:0]              w_nb;
    logic                    w_load;

    // Lane word bit z lands on state bit z; the state field is indexed [0:63].
    function automatic logic [0:63] to_field(input logic [63:0] w);
        logic [0:63] f;
        for (int z = 0; z < 64; z++) f[z] = w[z];
        return f;
    endfunction

    assign in_ready    = (r_state == ABSORB) && !restart;
    assign perm_start  = r_perm_start;
    assign state_out   = r_st;
    assign absorb_done = (r_state == DONE);

    always_comb begin
        w_nb = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        w_mask = '0;
        for (int k = 0; k < 8; k++)
            w_mask[8*k +: 8] = (!in_last || (4'(k) < w_nb)) ? 8'hFF : 8'h00;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_load      = 1'b0;
        for (int i = 0; i < 17; i++) w_xor[i] = '0;

        if (restart) begin
            w_state_nxt = ABSORB;
            w_cnt_nxt   = '0;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                ABSORB: begin
                    if (in_valid) begin
                        for (int i = 0; i < 17; i++)
                            if (5'(i) == r_cnt) w_xor[i] = in_data & w_mask;
                        if (!in_last) begin
                            if (r_cnt == 5'd16) begin
                                w_cnt_nxt   = '0;
                                w_state_nxt = PERM;
                            end else begin
                                w_cnt_nxt = r_cnt + 5'd1;
                            end
                        end else if (!w_nb[3]) begin
                            // Pad byte sits right after the last message byte.
                            for (int i = 0; i < 17; i++)
                                if (5'(i) == r_cnt)
                                    w_xor[i] = w_xor[i] ^ (64'h1F << {w_nb[2:0], 3'b000});
                            w_xor[16]   = w_xor[16] ^ 64'h8000_0000_0000_0000;
                            w_cnt_nxt   = '0;
                            w_state_nxt = PERM_FINAL;
                        end else if (r_cnt != 5'd16) begin
                            for (int i = 0; i < 17; i++)
                                if (5'(i) == r_cnt + 5'd1)
                                    w_xor[i] = w_xor[i] ^ 64'h1F;
                            w_xor[16]   = w_xor[16] ^ 64'h8000_0000_0000_0000;
                            w_cnt_nxt   = '0;
                            w_state_nxt = PERM_FINAL;
                        end else begin
                            w_cnt_nxt   = '0;
                            w_pend_nxt  = 1'b1;
                            w_state_nxt = PERM;
                        end
                    end
                end
                PERM: begin
                    if (perm_done && !r_perm_start) begin
                        w_load      = 1'b1;
                        w_state_nxt = r_pend ? PAD_BLOCK : ABSORB;
                    end
                end
                PAD_BLOCK: begin
                    w_xor[0]    = 64'h1F;
                    w_xor[16]   = 64'h8000_0000_0000_0000;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = PERM_FINAL;
                end
                PERM_FINAL: begin
                    if (perm_done && !r_perm_start) begin
                        w_load      = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = ABSORB;
                end
            endcase
        end

        w_perm_start_nxt = (w_state_nxt != r_state) &&
                           ((w_state_nxt == PERM) || (w_state_nxt == PERM_FINAL));
    end

    always_comb begin
        w_st_nxt = r_st;
        if (restart) begin
            w_st_nxt = '0;
        end else if (w_load) begin
            w_st_nxt = perm_state_in;
        end else begin
            for (int i = 0; i < 17; i++)
                w_st_nxt[i % 5][i / 5] = r_st[i % 5][i / 5] ^ to_field(w_xor[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ABSORB;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_perm_start <= 1'b0;
            r_st         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend       <= w_pend_nxt;
            r_perm_start <= w_perm_start_nxt;
            r_st         <= w_st_nxt;
        end
    end

endmodule

// File: tb/tb_shake256_absorb.sv
// Self-checking bench for shake256_absorb: random messages are padded by a
// byte-level SHAKE reference model and compared at every perm_start.
module tb_shake256_absorb;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  restart;
    logic                  in_valid;
    logic                  in_ready;
    logic [63:0]           in_data;
    logic                  in_last;
    logic [3:0]            in_bytes;
    logic                  perm_start;
    logic                  perm_done;
    logic [0:4][0:4][0:63] perm_state_in;
    logic [0:4][0:4][0:63] state_out;
    logic                  absorb_done;

    int total = 0;
    int bad   = 0;
    logic [7:0]  msg [$];
    logic [63:0] first_blk [25];
    logic [63:0] S [25];
    int hs_cnt, ps_cnt;

    shake256_absorb dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes), .perm_start(perm_start),
        .perm_done(perm_done), .perm_state_in(perm_state_in),
        .state_out(state_out), .absorb_done(absorb_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] get_lane(input logic [0:4][0:4][0:63] st, input int i);
        logic [63:0] r;
        for (int z = 0; z < 64; z++) r[z] = st[i % 5][i / 5][z];
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Drive a random "permutation result" and adopt it as the model state.
    task automatic drive_perm_result();
        for (int i = 0; i < 25; i++) begin
            S[i] = rand64();
            for (int z = 0; z < 64; z++) perm_state_in[i % 5][i / 5][z] = S[i][z];
        end
        perm_done = 1'b1;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart  = 1'b1;
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL restart_ready: in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        restart = 1'b0;
        for (int i = 0; i < 25; i++) S[i] = '0;
    endtask

    task automatic run_msg(input int gap);
        logic [7:0]  pad [$];
        logic [63:0] E [25];
        logic [63:0] lane;
        int n, L, nblk, nl, j, blk, done_blks, lat, nb;
        bit in_perm, fin, phase, ok;
        int bad_lane;
        n = msg.size();
        L = (n / 136 + 1) * 136;
        nblk = L / 136;
        nl = (n == 0) ? 1 : (n + 7) / 8;
        for (int k = 0; k < L; k++) pad.push_back(k < n ? msg[k] : 8'h00);
        pad[n]   = pad[n] ^ 8'h1F;
        pad[L-1] = pad[L-1] ^ 8'h80;

        pulse_restart();
        hs_cnt = 0; ps_cnt = 0;
        j = 0; blk = 0; done_blks = 0; lat = 0; in_perm = 0; fin = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            perm_done = 1'b0;
            phase = perm_start || in_perm;
            if (perm_start) begin
                ps_cnt++;
                total++;
                if (blk < nblk) begin
                    ok = 1; bad_lane = 0;
                    for (int i = 0; i < 25; i++) begin
                        lane = '0;
                        if (i < 17)
                            for (int k = 0; k < 8; k++) lane[8*k +: 8] = pad[blk*136 + 8*i + k];
                        E[i] = S[i] ^ lane;
                        if (ok && get_lane(state_out, i) !== E[i]) begin
                            ok = 0; bad_lane = i;
                        end
                    end
                    if (!ok) begin
                        bad++;
                        $display("FAIL block_state: blk=%0d lane=%0d got=%h required=%h",
                                 blk, bad_lane, get_lane(state_out, bad_lane), E[bad_lane]);
                    end
                    for (int i = 0; i < 25; i++) begin
                        S[i] = E[i];
                        if (blk == 0) first_blk[i] = get_lane(state_out, i);
                    end
                end else begin
                    bad++;
                    $display("FAIL extra_perm_start: count=%0d required %0d", ps_cnt, nblk);
                end
                blk++;
                in_perm = 1;
                lat = $urandom_range(0, 3);
            end else if (in_perm) begin
                if (lat == 0) begin
                    drive_perm_result();
                    in_perm = 0;
                    done_blks++;
                end else begin
                    lat--;
                end
            end else if (done_blks == nblk) begin
                total++;
                if (absorb_done !== 1'b1) begin
                    bad++;
                    $display("FAIL absorb_done: got=%b required 1", absorb_done);
                end
                ok = 1; bad_lane = 0;
                for (int i = 0; i < 25; i++)
                    if (ok && get_lane(state_out, i) !== S[i]) begin ok = 0; bad_lane = i; end
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL final_state: lane=%0d got=%h required=%h",
                             bad_lane, get_lane(state_out, bad_lane), S[bad_lane]);
                end
                fin = 1;
            end
            if (!fin && done_blks < nblk) begin
                total++;
                if (absorb_done !== 1'b0) begin
                    bad++;
                    $display("FAIL early_done: absorb_done=%b required 0", absorb_done);
                end
            end
            if (phase) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_in_perm: in_ready=%b required 0", in_ready);
                end
            end
            in_valid = (j < nl) && ($urandom_range(0, 99) >= gap);
            in_data  = rand64();
            in_last  = (j == nl - 1);
            nb = n - 8 * j;
            if (!in_last) in_bytes = 4'($urandom_range(0, 15));
            else if (nb >= 8) in_bytes = 4'($urandom_range(8, 15));
            else in_bytes = 4'(nb);
            for (int k = 0; k < 8; k++)
                if (8 * j + k < n) in_data[8*k +: 8] = msg[8 * j + k];
            if (in_valid && in_ready) begin
                hs_cnt++;
                j++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        perm_done = 1'b0;
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL timeout: message of %0d bytes did not complete", n);
        end
        total++;
        if (hs_cnt != nl) begin
            bad++;
            $display("FAIL handshakes: got=%0d required=%0d", hs_cnt, nl);
        end
        total++;
        if (ps_cnt != nblk) begin
            bad++;
            $display("FAIL perm_start_count: got=%0d required=%0d", ps_cnt, nblk);
        end
    endtask

    task automatic fill_msg(input int n);
        msg.delete();
        for (int k = 0; k < n; k++) msg.push_back(8'($urandom()));
    endtask

    task automatic feed_full_block();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = rand64();
            in_last  = 1'b0;
            in_bytes = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_zero_state(input string name);
        bit ok;
        ok = 1;
        for (int i = 0; i < 25; i++) if (get_lane(state_out, i) !== 64'h0) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: state_out lane0=%h required all zero", name, get_lane(state_out, 0));
        end
    endtask

    task automatic test_reset();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b required 1", in_ready); end
        total++;
        if (perm_start !== 1'b0) begin bad++; $display("FAIL reset_perm_start: got=%b required 0", perm_start); end
        total++;
        if (absorb_done !== 1'b0) begin bad++; $display("FAIL reset_done: got=%b required 0", absorb_done); end
        check_zero_state("reset_state");
    endtask

    task automatic test_empty();
        bit ok;
        msg.delete();
        run_msg(0);
        ok = (first_blk[0] === 64'h1F) && (first_blk[16] === 64'h8000_0000_0000_0000);
        for (int i = 1; i < 16; i++) if (first_blk[i] !== 64'h0) ok = 0;
        for (int i = 17; i < 25; i++) if (first_blk[i] !== 64'h0) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL empty_msg: lane0=%h lane16=%h required 1f / 8000000000000000",
                     first_blk[0], first_blk[16]);
        end
    endtask

    task automatic test_abc();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(30);
        total++;
        if (first_blk[0] !== 64'h0000_0000_1F63_6261 || first_blk[16] !== 64'h8000_0000_0000_0000) begin
            bad++;
            $display("FAIL abc_msg: lane0=%h lane16=%h required 000000001f636261 / 8000000000000000",
                     first_blk[0], first_blk[16]);
        end
    endtask

    task automatic test_135();
        fill_msg(135);
        run_msg(0);
        total++;
        if (first_blk[16][63:56] !== 8'h9F) begin
            bad++;
            $display("FAIL msg135_byte: lane16 byte7=%h required 9f", first_blk[16][63:56]);
        end
    endtask

    task automatic test_136();
        fill_msg(136);
        run_msg(20);
    endtask

    task automatic test_back_to_back();
        fill_msg(160);
        run_msg(40);
        for (int t = 0; t < 8; t++) begin
            fill_msg($urandom_range(0, 300));
            run_msg($urandom_range(0, 60));
        end
    endtask

    task automatic test_restart_perm();
        bit seen;
        pulse_restart();
        feed_full_block();
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            if (perm_start) seen = 1; else @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL restart_perm_start: perm_start=0 required 1"); end
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        drive_perm_result();
        @(negedge clk);
        perm_done = 1'b0;
        check_zero_state("restart_state");
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL restart_in_ready: got=%b required 1", in_ready); end
        total++;
        if (absorb_done !== 1'b0 || perm_start !== 1'b0) begin
            bad++;
            $display("FAIL restart_flags: absorb_done=%b perm_start=%b required 0 0", absorb_done, perm_start);
        end
    endtask

    task automatic test_async_reset();
        pulse_restart();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = rand64() | 64'h1; in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_zero_state("areset_absorb_state");
        total++;
        if (in_ready !== 1'b1 || perm_start !== 1'b0 || absorb_done !== 1'b0) begin
            bad++;
            $display("FAIL areset_absorb_flags: ready=%b start=%b done=%b required 1 0 0",
                     in_ready, perm_start, absorb_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        feed_full_block();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero_state("areset_perm_state");
        @(negedge clk);
        rst_n = 1'b1;
        drive_perm_result();
        @(negedge clk);
        perm_done = 1'b0;
        check_zero_state("stale_done_state");
        total++;
        if (in_ready !== 1'b1 || perm_start !== 1'b0 || absorb_done !== 1'b0) begin
            bad++;
            $display("FAIL stale_done_flags: ready=%b start=%b done=%b required 1 0 0",
                     in_ready, perm_start, absorb_done);
        end
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; in_bytes = '0; perm_done = 1'b0; perm_state_in = '0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_empty();
        test_abc();
        test_135();
        test_136();
        test_back_to_back();
        test_restart_perm();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
